// File: rtl/e203_clkgate_pkg.sv
// Shared types for the multi-channel clock-gating controller.
// Per-channel FSM state encoding and its width.
package e203_clkgate_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_ON   = 2'd0,
        ST_OFF  = 2'd1,
        ST_WAKE = 2'd2
    } cg_state_e;

endpackage

// File: rtl/e203_clkgate.sv
// Latch-based glitch-free clock gate: enable is captured while the clock is low,
// so an enable change only ever shows up at the start of a full high phase.
module e203_clkgate (
    input  logic i_clk,
    input  logic i_en,
    input  logic i_testMode,
    output logic o_clk
);

    logic r_enLat;

    always_latch begin
        if (!i_clk) r_enLat <= i_en | i_testMode;
    end

    assign o_clk = i_clk & r_enLat;

endmodule

// File: rtl/e203_clkgate_ch_fsm.sv
// One gated-clock channel: ON/OFF/WAKE state machine with idle and wake counters.
// Gates after idle_thresh consecutive quiet cycles; wakes through a fixed settle delay.
module e203_clkgate_ch_fsm
    import e203_clkgate_pkg::*;
#(
    parameter int IDLE_CW  = 8,
    parameter int WAKE_CYC = 2,
    parameter int RST_ON   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_autoGateEn,
    input  logic [IDLE_CW-1:0] i_idleThresh,
    input  logic               i_active,
    input  logic               i_forceOn,
    input  logic               i_req,
    output logic               o_clkEn,
    output logic               o_gated,
    output logic               o_ack
);

    localparam int WCW = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;
    localparam logic [WCW-1:0] WLAST = WCW'((WAKE_CYC > 0) ? WAKE_CYC - 1 : 0);
    localparam cg_state_e RST_STATE = (RST_ON != 0) ? ST_ON : ST_OFF;

    cg_state_e          r_state;
    logic [IDLE_CW-1:0] r_icnt;
    logic [WCW-1:0]     r_wcnt;

    logic               w_quiet;
    logic               w_wake;
    logic [IDLE_CW:0]   w_icntNext;
    logic               w_threshHit;

    assign w_quiet     = i_autoGateEn & ~i_active & ~i_forceOn & ~i_req;
    assign w_wake      = ~w_quiet;
    assign w_icntNext  = {1'b0, r_icnt} + {{IDLE_CW{1'b0}}, 1'b1};
    // >= rather than == so a threshold lowered below the running count still gates
    assign w_threshHit = (i_idleThresh != '0) && (w_icntNext >= {1'b0, i_idleThresh});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RST_STATE;
            r_icnt  <= '0;
            r_wcnt  <= '0;
        end else begin
            case (r_state)
                ST_ON: begin
                    if (!w_quiet || i_idleThresh == '0) begin
                        r_icnt <= '0;
                    end else if (w_threshHit) begin
                        r_state <= ST_OFF;
                        r_icnt  <= '0;
                    end else begin
                        r_icnt <= w_icntNext[IDLE_CW-1:0];
                    end
                end
                ST_OFF: begin
                    if (w_wake) begin
                        r_wcnt  <= '0;
                        r_icnt  <= '0;
                        r_state <= (WAKE_CYC == 0) ? ST_ON : ST_WAKE;
                    end
                end
                ST_WAKE: begin
                    r_wcnt <= r_wcnt + WCW'(1);
                    if (r_wcnt == WLAST) begin
                        r_state <= ST_ON;
                        r_icnt  <= '0;
                    end
                end
                default: begin
                    r_state <= RST_STATE;
                    r_icnt  <= '0;
                    r_wcnt  <= '0;
                end
            endcase
        end
    end

    assign o_clkEn = (r_state != ST_OFF);
    assign o_gated = (r_state == ST_OFF);
    assign o_ack   = i_req & (r_state == ST_ON);

endmodule

// File: rtl/e203_clkgate_ctrl.sv
// Multi-channel clock-gating controller: one FSM and one latch-based gate per channel.
// Channels are fully independent; test_mode forces every gated clock to run.
module e203_clkgate_ctrl
    import e203_clkgate_pkg::*;
#(
    parameter int CH_NUM   = 4,
    parameter int IDLE_CW  = 8,
    parameter int WAKE_CYC = 2,
    parameter int RST_ON   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               test_mode,
    input  logic               auto_gate_en,
    input  logic [IDLE_CW-1:0] idle_thresh,
    input  logic [CH_NUM-1:0]  ch_active,
    input  logic [CH_NUM-1:0]  ch_force_on,
    input  logic [CH_NUM-1:0]  ch_req,
    output logic [CH_NUM-1:0]  ch_ack,
    output logic [CH_NUM-1:0]  ch_gated,
    output logic [CH_NUM-1:0]  ch_clk_en,
    output logic [CH_NUM-1:0]  ch_clk_out
);

    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
        e203_clkgate_ch_fsm #(
            .IDLE_CW  (IDLE_CW),
            .WAKE_CYC (WAKE_CYC),
            .RST_ON   (RST_ON)
        ) u_fsm (
            .clk          (clk),
            .rst          (rst),
            .i_autoGateEn (auto_gate_en),
            .i_idleThresh (idle_thresh),
            .i_active     (ch_active[gi]),
            .i_forceOn    (ch_force_on[gi]),
            .i_req        (ch_req[gi]),
            .o_clkEn      (ch_clk_en[gi]),
            .o_gated      (ch_gated[gi]),
            .o_ack        (ch_ack[gi])
        );

        e203_clkgate u_gate (
            .i_clk      (clk),
            .i_en       (ch_clk_en[gi]),
            .i_testMode (test_mode),
            .o_clk      (ch_clk_out[gi])
        );
    end

endmodule
